// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the IF/MEM memory port arbiter.
//   arb_state_e : transaction FSM states
//   arb_sel_e   : which requester owns the current transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
  typedef enum logic {SEL_IF, SEL_DATA} arb_sel_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive data selections made while fetch is
// waiting, and flags when fetch must win the next arbitration.
// Only built when MEM_ARB_STARVE_GUARD_EN is defined.
//   clk, rst  : clock, async active-high reset
//   idle      : arbiter is in IDLE (arbitration cycle)
//   if_req    : fetch request pending
//   pick_data : this IDLE cycle selects the data requester
//   trip      : count has reached STARVE_MAX
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic pick_data,
  output logic trip
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // With if_req high, every IDLE cycle is an arbitration, so "not data"
  // means fetch was selected and the count restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (idle) begin
      if (!if_req || !pick_data)
        cnt <= '0;
      else if (!trip)
        cnt <= cnt + 1'b1;
    end
  end

  assign trip = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (IF) and
// load/store (MEM). One transaction outstanding; data wins by default.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
//   if_req/if_addr            -> if_done/if_rdata  : fetch read, hold until done
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_done/d_rdata : data access
//   mem_req/we/addr/wdata/wstrb, mem_gnt          : memory command handshake
//   mem_rvalid/mem_rdata                          : one response per command
// All outputs come from registers or FSM state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (STARVE_MAX < 1 || DATA_W % 8 != 0) begin : g_bad_cfg
    $error("mem_port_arbiter: STARVE_MAX must be >= 1, DATA_W a multiple of 8");
  end

  arb_state_e state, state_nxt;
  arb_sel_e   sel;
  logic       trip;
  logic       pick_data;
  logic       any_req;

  assign any_req   = if_req || d_req;
  // Data wins unless the guard has tripped and fetch is actually waiting.
  assign pick_data = d_req && (!trip || !if_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .idle      (state == IDLE),
    .if_req    (if_req),
    .pick_data (pick_data),
    .trip      (trip)
  );
`else
  assign trip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)    state_nxt = ISSUE;
      ISSUE:   if (mem_gnt)    state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  assign mem_req = (state == ISSUE);
  assign if_done = (state == DONE) && (sel == SEL_IF);
  assign d_done  = (state == DONE) && (sel == SEL_DATA);

  // Command latch and response registers. mem_rvalid is only honoured in
  // WAIT, so responses left over from before a reset are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= SEL_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        if (pick_data) begin
          sel       <= SEL_DATA;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_wstrb <= d_wstrb;
        end else begin
          sel       <= SEL_IF;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      end
      if (state == WAIT && mem_rvalid) begin
        if (sel == SEL_IF) if_rdata <= mem_rdata;
        else               d_rdata  <= mem_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. The memory side
// is driven cycle by cycle from the stimulus; expected values are hand-set.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_req"},   64'(mem_req),   64'h0);
    chk({tag, ".mem_we"},    64'(mem_we),    64'h0);
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'h0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'h0);
    chk({tag, ".if_done"},   64'(if_done),   64'h0);
    chk({tag, ".d_done"},    64'(d_done),    64'h0);
    chk({tag, ".if_rdata"},  64'(if_rdata),  64'h0);
    chk({tag, ".d_rdata"},   64'(d_rdata),   64'h0);
  endtask

  // Entered in the IDLE cycle where the request is first presented; returns
  // in the DONE cycle. gdly = cycles of mem_gnt low while in ISSUE.
  task automatic serve(input string tag, input int gdly, input bit exp_if,
                       input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                       input logic [31:0] rd, input logic [31:0] exp_rdata);
    tick();
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt = (i == gdly);
      chk({tag, ".mem_req"},   64'(mem_req),   64'h1);
      chk({tag, ".mem_we"},    64'(mem_we),    64'(exp_we));
      chk({tag, ".mem_addr"},  64'(mem_addr),  64'(exp_addr));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'(exp_wstrb));
      chk({tag, ".early_done"}, 64'({if_done, d_done}), 64'h0);
      tick();
    end
    mem_gnt = 1'b0;
    chk({tag, ".wait_req"}, 64'(mem_req), 64'h0);
    chk({tag, ".wait_done"}, 64'({if_done, d_done}), 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk({tag, ".if_done"}, 64'(if_done), 64'(exp_if));
    chk({tag, ".d_done"},  64'(d_done),  64'(!exp_if));
    if (exp_if) chk({tag, ".if_rdata"}, 64'(if_rdata), 64'(exp_rdata));
    else        chk({tag, ".d_rdata"},  64'(d_rdata),  64'(exp_rdata));
  endtask

  initial begin
    bit guard_en;
    bit is_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard_en = 1'b1;
`else
    guard_en = 1'b0;
`endif
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    chk_reset("por");
    rst = 1'b0;
    tick();

    // Fetch only
    if_req = 1; if_addr = 32'h100;
    serve("fetch", 0, 1, 0, 32'h100, 0, 0, 32'h00000013, 32'h00000013);
    if_req = 0;
    tick();
    chk("fetch.pulse_end", 64'(if_done), 64'h0);

    // Simultaneous store and fetch: data first, fetch done at cycle 7
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    serve("store", 0, 0, 1, 32'h200, 32'hDEADBEEF, 4'hF, 32'h12345678, 32'h0);
    d_req = 0; d_we = 0;
    tick();
    serve("fetch2", 0, 1, 0, 32'h104, 0, 0, 32'h00100093, 32'h00100093);
    if_req = 0;
    tick();

    // Grant withheld for 5 cycles
    d_req = 1; d_we = 0; d_addr = 32'h240; d_wdata = 32'hCAFEF00D; d_wstrb = 4'h0;
    serve("gnt5", 5, 0, 0, 32'h240, 32'hCAFEF00D, 4'h0, 32'hA5A55A5A, 32'hA5A55A5A);
    d_req = 0;
    tick();

    // Fetch held off by continuous data traffic
    if_req = 1; if_addr = 32'h108;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 0; d_wstrb = 0;
    for (int k = 0; k < 6; k++) begin
      is_if = guard_en && (k == 4);
      serve($sformatf("starve%0d", k), 0, is_if, 0, is_if ? 32'h108 : 32'h300,
            0, 0, 32'h1000 + k, 32'h1000 + k);
      if (k == 5) begin
        if_req = 0; d_req = 0;
      end
      tick();
    end

    // Byte store: write response data never reaches d_rdata
    d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h0000AB00; d_wstrb = 4'h2;
    serve("bstore", 0, 0, 1, 32'h204, 32'h0000AB00, 4'h2, 32'hFFFFFFFF, 32'h0);
    d_req = 0; d_we = 0;
    tick();

    // Reset during WAIT, then a stale response
    if_req = 1; if_addr = 32'h10C;
    tick();
    mem_gnt = 1;
    chk("rstw.issue", 64'(mem_req), 64'h1);
    tick();
    mem_gnt = 0;
    rst = 1;
    #1;
    chk_reset("rstw");
    if_req = 0;
    tick();
    rst = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h00000BAD;
    tick();
    mem_rvalid = 0; mem_rdata = 0;
    chk_reset("stale1");
    tick();
    chk_reset("stale2");

    // Normal service after reset
    if_req = 1; if_addr = 32'h110;
    serve("post", 0, 1, 0, 32'h110, 0, 0, 32'h00000033, 32'h00000033);
    if_req = 0;
    tick();
    chk("post.idle", 64'({mem_req, if_done, d_done}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
